uart_rx_core: RTL and testbench

Serial receive engine for the memory-mapped UART of the pipelined RISC-V core. It sits directly upstream of the data path's UART peripheral registers: it takes the asynchronous `uart_rx` pin, recovers 8N1 frames, and presents each received byte in a one-entry holding register. The load/store stage reads and acknowledges that register. Status flags report framing errors and overruns for software polling.

---
 rtl/uart_rx_core.sv | 141 ++++++++++++++
 tb/tb_uart_rx_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// 8N1 serial receive engine with a one-entry holding register and sticky
// framing/overrun status flags, clocked in a single domain.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ack_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       clr_err_i,
  output logic       busy_o
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shift, shift_next;
  logic            sync1, rx_s;
  logic            load, ferr_set, ovr_set;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    load         = 1'b0;
    ferr_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_next = S_START;
          cnt_next   = '0;
        end
      end
      S_START: begin
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(HALF - 1)) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = S_DATA;
            bit_idx_next = '0;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          shift_next[bit_idx] = rx_s;
          cnt_next            = '0;
          if (bit_idx == 3'd7) state_next = S_STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_next = '0;
          if (rx_s) begin
            load       = 1'b1;
            state_next = S_IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ovr_set = load && rx_valid_o && !rx_ack_i;

  // Holding register and sticky flags; a set event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_o   <= 8'h00;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      if (load) begin
        rx_data_o  <= shift;
        rx_valid_o <= 1'b1;
      end else if (rx_ack_i) begin
        rx_valid_o <= 1'b0;
      end
      if (ferr_set)       frame_err_o <= 1'b1;
      else if (clr_err_i) frame_err_o <= 1'b0;
      if (ovr_set)        overrun_o <= 1'b1;
      else if (clr_err_i) overrun_o <= 1'b0;
      busy_o <= (state_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed and randomized frames against a frame-level model of the
// receiver's holding register and status flags.
module tb_uart_rx_core;

  localparam int unsigned CPB = 8;

  logic       clk;
  logic       reset;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ack_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       clr_err_i;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ack_i    (rx_ack_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .clr_err_i   (clr_err_i),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ack();
    rx_ack_i = 1'b1;
    tick();
    rx_ack_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
  endtask

  // Drives one frame starting at the current cycle E; strobes can be placed
  // in the stop-sample cycle (E+78) so they coincide with the load.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic ack_ld, input logic clr_ld,
                            output logic v_pre, output logic v_post,
                            output logic [7:0] d_post, output logic fe_post,
                            output logic ov_post, output logic busy_mid);
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 8; k++) begin
      rx_i = b[k];
      if (k == 4) busy_mid = busy_o;
      repeat (CPB) tick();
    end
    rx_i = stop;
    repeat (6) tick();
    v_pre     = rx_valid_o;
    rx_ack_i  = ack_ld;
    clr_err_i = clr_ld;
    tick();
    rx_ack_i  = 1'b0;
    clr_err_i = 1'b0;
    v_post  = rx_valid_o;
    d_post  = rx_data_o;
    fe_post = frame_err_o;
    ov_post = overrun_o;
    tick();
  endtask

  logic       v_pre, v_post, fe_post, ov_post, busy_mid;
  logic [7:0] d_post;
  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_ovr;
  logic [7:0] rb;
  logic       rstop;

  initial begin
    reset = 1'b1; rx_i = 1'b1; rx_ack_i = 1'b0; clr_err_i = 1'b0;
    repeat (3) tick();
    chk("rst_data",  rx_data_o,   8'h00);
    chk("rst_valid", rx_valid_o,  1'b0);
    chk("rst_ferr",  frame_err_o, 1'b0);
    chk("rst_ovr",   overrun_o,   1'b0);
    chk("rst_busy",  busy_o,      1'b0);
    reset = 1'b0;
    repeat (3) tick();

    // Good frame, exact load latency
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, v_pre, v_post, d_post, fe_post, ov_post, busy_mid);
    chk("a5_busy_mid",  busy_mid, 1'b1);
    chk("a5_valid_pre", v_pre,    1'b0);
    chk("a5_valid",     v_post,   1'b1);
    chk("a5_data",      d_post,   8'hA5);
    chk("a5_ferr",      fe_post,  1'b0);
    chk("a5_ovr",       ov_post,  1'b0);
    tick();
    chk("a5_busy_after", busy_o, 1'b0);
    pulse_ack();
    chk("a5_ack_valid", rx_valid_o, 1'b0);
    chk("a5_ack_data",  rx_data_o,  8'hA5);

    // Start-bit glitch is dropped silently
    rx_i = 1'b0;
    repeat (2) tick();
    rx_i = 1'b1;
    repeat (8) tick();
    chk("glitch_busy",  busy_o,      1'b0);
    chk("glitch_valid", rx_valid_o,  1'b0);
    chk("glitch_ferr",  frame_err_o, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, v_pre, v_post, d_post, fe_post, ov_post, busy_mid);
    chk("5a_valid", v_post, 1'b1);
    chk("5a_data",  d_post, 8'h5A);
    pulse_ack();

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, v_pre, v_post, d_post, fe_post, ov_post, busy_mid);
    chk("3c_ferr",  fe_post, 1'b1);
    chk("3c_valid", v_post,  1'b0);
    chk("3c_data",  d_post,  8'h5A);
    repeat (32) tick();
    chk("3c_busy_break", busy_o, 1'b1);
    rx_i = 1'b1;
    repeat (5) tick();
    chk("3c_busy_idle", busy_o, 1'b0);
    pulse_clr();
    chk("3c_clr_ferr", frame_err_o, 1'b0);

    // Back-to-back overrun; set beats a same-cycle clear
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, v_pre, v_post, d_post, fe_post, ov_post, busy_mid);
    chk("11_data", d_post, 8'h11);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1, v_pre, v_post, d_post, fe_post, ov_post, busy_mid);
    chk("22_data",  d_post,  8'h22);
    chk("22_valid", v_post,  1'b1);
    chk("22_ovr",   ov_post, 1'b1);
    pulse_clr();
    chk("22_clr_ovr", overrun_o, 1'b0);

    // Ack coinciding with load: no overrun
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0, v_pre, v_post, d_post, fe_post, ov_post, busy_mid);
    chk("7e_valid_pre", v_pre,   1'b1);
    chk("7e_data",      d_post,  8'h7E);
    chk("7e_valid",     v_post,  1'b1);
    chk("7e_ovr",       ov_post, 1'b0);

    // Reset during data bit 4 of 0xFF
    rx_i = 1'b0;
    repeat (CPB) tick();
    rx_i = 1'b1;
    repeat (4 * CPB + 4) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_data",  rx_data_o,   8'h00);
    chk("mid_rst_valid", rx_valid_o,  1'b0);
    chk("mid_rst_ferr",  frame_err_o, 1'b0);
    chk("mid_rst_ovr",   overrun_o,   1'b0);
    chk("mid_rst_busy",  busy_o,      1'b0);
    reset = 1'b0;
    repeat (4 * CPB) tick();
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, v_pre, v_post, d_post, fe_post, ov_post, busy_mid);
    chk("81_data",  d_post,  8'h81);
    chk("81_valid", v_post,  1'b1);
    chk("81_ferr",  fe_post, 1'b0);
    chk("81_ovr",   ov_post, 1'b0);

    // Randomized frames against a frame-level model
    m_data = 8'h81; m_valid = 1'b1; m_ferr = 1'b0; m_ovr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        m_valid = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
      end
      repeat ($urandom_range(0, 4)) tick();
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      send_frame(rb, rstop, 1'b0, 1'b0, v_pre, v_post, d_post, fe_post, ov_post, busy_mid);
      if (rstop) begin
        if (m_valid) m_ovr = 1'b1;
        m_data  = rb;
        m_valid = 1'b1;
      end else begin
        m_ferr = 1'b1;
        repeat ($urandom_range(0, 20)) tick();
        rx_i = 1'b1;
        repeat (5) tick();
      end
      tick();
      chk("rnd_data",  rx_data_o,   m_data);
      chk("rnd_valid", rx_valid_o,  m_valid);
      chk("rnd_ferr",  frame_err_o, m_ferr);
      chk("rnd_ovr",   overrun_o,   m_ovr);
      chk("rnd_busy",  busy_o,      1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
